ws_pe_dbuf: RTL and testbench
=============================

// Module: ws_pe_dbuf
// PURPOSE
//  Weight-stationary systolic PE with a double-buffered (shadow/active) weight, so the next weight
//  tile shifts in while MACs continue on the current one. Replaces the single-register PE in
//  the MAC array: A flows east, partial sums flow south, and weights shift south via b_in/b_out.
//  Adds signed/unsigned operands, a 1- or 2-stage MAC pipeline, optional saturation and a
//  sticky overflow flag.
// PARAMETERS
//  DATA_WIDTH  8   operand width of A and weight
//  ACC_WIDTH   32  partial-sum width; must be >= 2*DATA_WIDTH
//  PIPE        1   MAC latency: 1 = mult+add in one cycle; 2 = product registered, then add
//  SAT         0   1 = saturate on accumulate overflow; 0 = two's-complement wrap
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           asynchronous, active-low reset
//  enable       in   1           advances A/C/valid pipeline; 0 = hold (stall)
//  signed_mode  in   1           1 = A and weight are signed; 0 = unsigned (static per tile)
//  b_load       in   1           shift weight chain: shadow <= b_in
//  b_in         in   DATA_WIDTH  weight from PE above
//  b_out        out  DATA_WIDTH  shadow register, to PE below
//  b_swap       in   1           active <= shadow
//  valid_in     in   1           qualifies a_in and c_in
//  a_in         in   DATA_WIDTH  activation from west
//  a_out        out  DATA_WIDTH  activation to east, 1-cycle delay
//  c_in         in   ACC_WIDTH   partial sum from north
//  c_out        out  ACC_WIDTH   partial sum to south, PIPE-cycle delay
//  valid_out    out  1           valid_in delayed to match c_out
//  ovf_clr      in   1           synchronous clear of ovf
//  ovf          out  1           sticky: set when an accumulate overflowed (wrap or sat)
// BEHAVIOUR
//  - Reset (async, rst=0): shadow, active, a_out, c_out, valid_out, ovf, pipeline regs -> 0.
//    Asserting reset mid-operation drops in-flight data; the first valid_out after release
//    comes from operands presented after release.
//  - Weight path ignores enable. b_load: shadow <= b_in, so b_out shows the new value the next
//    cycle. b_swap: active <= shadow. Both in one cycle: active <= OLD shadow, shadow <= b_in.
//  - Operands use the active weight at the cycle they enter. With PIPE=2, a swap never corrupts
//    an in-flight product.
//  - enable=1: a_out <= a_in (1 cycle). The product is taken on sign-/zero-extended operands per
//    signed_mode. Product is forced to 0 when valid_in=0. Sum = c_in + product, held at ACC_WIDTH.
//  - PIPE=1: c_out, valid_out update the same edge as a_out. PIPE=2: stage1 captures {product,
//    c_in, valid_in}; stage2 adds. Latency is 2 and throughput 1/cycle.
//  - enable=0: every A/C/valid register, including stage1, holds. Outputs remain stable.
//  - Overflow is only meaningful when valid. Signed: operand signs are equal and the result sign
//    differs. Unsigned: carry out of ACC_WIDTH. SAT=1 clamps signed to [-2^(ACC-1), 2^(ACC-1)-1]
//    and unsigned to [0, 2^ACC-1]. SAT=0 wraps.
//  - ovf: set when an overflowed sum is registered. ovf_clr clears it. If clear and set happen in
//    the same cycle, set wins.
// STRUCTURE
//  - ws_pkg: ws_pipe_e {PIPE_1, PIPE_2}, plus a function sat_add(a, b, signed_mode, sat) returning
//    {ovf, sum}. ws_pkg is shared with the array and its tests.
//  - Sub-module ws_acc_sat: combinational accumulate/saturate/overflow detect, reused by the
//    output-stationary PE.
//  - Top: weight shadow/active registers, A register, PIPE generate block.
// TESTING
//  1. Weight load/swap: b_load=1,b_in=5 then b_swap; a=2,c_in=10,valid -> c_out=20, valid_out=1
//     after PIPE; b_out=5.
//  2. Double buffer: active=5; load b_in=-3 while streaming a=1,2,3 (c_in=0) -> 5,10,15; swap,
//     a=-4,c_in=15 -> c_out=27.
//  3. Load+swap same cycle: shadow=7, b_in=9 -> active=7, shadow=9, b_out=9 next cycle.
//  4. Saturation SAT=1, signed, ACC=32: c_in=0x7FFFFFF0, a=5, w=5 -> c_out=0x7FFFFFFF, ovf=1.
//     SAT=0 -> 0x80000009. ovf_clr -> 0.
//  5. Unsigned: signed_mode=0, a=8'hFF, w=8'hFF, c_in=0 -> c_out=65025. Signed: same bits -> 1.
//  6. Stall/reset: valid stream with PIPE=2, enable=0 for 3 cycles -> outputs frozen, no data
//     lost; rst=0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared types and accumulate helper for the weight-stationary PE family
package ws_pkg;

    typedef enum logic {
        PIPE_1,
        PIPE_2
    } ws_pipe_e;

    localparam int WS_ACC_W = 32;

    // Returns {ovf, sum}; signed overflow is same-sign operands giving a different-sign result.
    function automatic logic [WS_ACC_W:0] sat_add(
        input logic [WS_ACC_W-1:0] a,
        input logic [WS_ACC_W-1:0] b,
        input logic                signed_mode,
        input logic                sat
    );
        logic [WS_ACC_W:0]   full;
        logic [WS_ACC_W-1:0] sum;
        logic                ovf;
        full = {1'b0, a} + {1'b0, b};
        sum  = full[WS_ACC_W-1:0];
        if (signed_mode) begin
            ovf = (a[WS_ACC_W-1] == b[WS_ACC_W-1]) && (sum[WS_ACC_W-1] != a[WS_ACC_W-1]);
        end else begin
            ovf = full[WS_ACC_W];
        end
        if (sat && ovf) begin
            if (signed_mode) begin
                sum = a[WS_ACC_W-1] ? {1'b1, {(WS_ACC_W-1){1'b0}}} : {1'b0, {(WS_ACC_W-1){1'b1}}};
            end else begin
                sum = '1;
            end
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/ws_acc_sat.sv
// rtl/ws_acc_sat.sv - combinational accumulate with overflow detect and optional saturation
module ws_acc_sat
    import ws_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int SAT       = 0
) (
    input  logic [ACC_WIDTH-1:0] c,
    input  logic [ACC_WIDTH-1:0] p,
    input  logic                 signed_mode,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    localparam int MSB = ACC_WIDTH - 1;

    logic [ACC_WIDTH:0]   full;
    logic [ACC_WIDTH-1:0] raw;
    logic                 signed_ovf;

    assign full       = {1'b0, c} + {1'b0, p};
    assign raw        = full[MSB:0];
    assign signed_ovf = (c[MSB] == p[MSB]) && (raw[MSB] != c[MSB]);

    always_comb begin
        ovf = signed_mode ? signed_ovf : full[ACC_WIDTH];
        sum = raw;
        if (SAT != 0 && ovf) begin
            // Clamp toward the direction of the overflow: the shared operand sign picks the rail.
            if (signed_mode) begin
                sum = c[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
            end else begin
                sum = '1;
            end
        end
    end

endmodule

// File: rtl/ws_pe_dbuf.sv
// rtl/ws_pe_dbuf.sv - weight-stationary systolic PE with shadow/active weight double buffer
module ws_pe_dbuf
    import ws_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int PIPE       = 1,
    parameter int SAT        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  signed_mode,
    input  logic                  b_load,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] b_out,
    input  logic                  b_swap,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    output logic [DATA_WIDTH-1:0] a_out,
    input  logic [ACC_WIDTH-1:0]  c_in,
    output logic [ACC_WIDTH-1:0]  c_out,
    output logic                  valid_out,
    input  logic                  ovf_clr,
    output logic                  ovf
);

    localparam ws_pipe_e PIPE_MODE = (PIPE == 2) ? PIPE_2 : PIPE_1;

    logic [DATA_WIDTH-1:0] shadow;
    logic [DATA_WIDTH-1:0] active;

    // Weight chain runs regardless of enable so tiles can preload during stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (b_load) shadow <= b_in;
            if (b_swap) active <= shadow;
        end
    end

    assign b_out = shadow;

    logic signed [ACC_WIDTH-1:0] a_ext;
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic signed [ACC_WIDTH-1:0] prod;
    logic        [ACC_WIDTH-1:0] prod_v;

    assign a_ext  = ACC_WIDTH'($signed({signed_mode & a_in[DATA_WIDTH-1], a_in}));
    assign w_ext  = ACC_WIDTH'($signed({signed_mode & active[DATA_WIDTH-1], active}));
    assign prod   = a_ext * w_ext;
    assign prod_v = valid_in ? prod : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
        end else if (enable) begin
            a_out <= a_in;
        end
    end

    logic [ACC_WIDTH-1:0] acc_c;
    logic [ACC_WIDTH-1:0] acc_p;
    logic                 acc_v;
    logic                 acc_sm;

    generate
        if (PIPE_MODE == PIPE_2) begin : g_pipe2
            logic [ACC_WIDTH-1:0] p1;
            logic [ACC_WIDTH-1:0] c1;
            logic                 v1;
            logic                 sm1;

            // Product is frozen here, so a later swap cannot touch an in-flight operand.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p1  <= '0;
                    c1  <= '0;
                    v1  <= 1'b0;
                    sm1 <= 1'b0;
                end else if (enable) begin
                    p1  <= prod_v;
                    c1  <= c_in;
                    v1  <= valid_in;
                    sm1 <= signed_mode;
                end
            end

            assign acc_c  = c1;
            assign acc_p  = p1;
            assign acc_v  = v1;
            assign acc_sm = sm1;
        end else begin : g_pipe1
            assign acc_c  = c_in;
            assign acc_p  = prod_v;
            assign acc_v  = valid_in;
            assign acc_sm = signed_mode;
        end
    endgenerate

    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 acc_ovf;

    ws_acc_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SAT       (SAT)
    ) u_acc (
        .c           (acc_c),
        .p           (acc_p),
        .signed_mode (acc_sm),
        .sum         (acc_sum),
        .ovf         (acc_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_out     <= '0;
            valid_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (enable) begin
                c_out     <= acc_sum;
                valid_out <= acc_v;
            end
            // Set is written last so it wins over a same-cycle clear.
            if (ovf_clr) ovf <= 1'b0;
            if (enable && acc_v && acc_ovf) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ws_pe_dbuf.sv
// tb/tb_ws_pe_dbuf.sv - directed vector bench for ws_pe_dbuf (PIPE=1/SAT=1 and PIPE=2/SAT=0)
module tb_ws_pe_dbuf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        signed_mode = 1'b1;
    logic        b_load = 1'b0;
    logic        b_swap = 1'b0;
    logic        valid_in = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  b_in = '0;
    logic [7:0]  a_in = '0;
    logic [31:0] c_in = '0;

    logic [7:0]  b_out1, a_out1, b_out2, a_out2;
    logic [31:0] c_out1, c_out2;
    logic        vo1, vo2, ovf1, ovf2;

    always #5 clk = ~clk;

    ws_pe_dbuf #(.DATA_WIDTH(8), .ACC_WIDTH(32), .PIPE(1), .SAT(1)) u_p1 (
        .clk(clk), .rst(rst), .enable(enable), .signed_mode(signed_mode),
        .b_load(b_load), .b_in(b_in), .b_out(b_out1), .b_swap(b_swap),
        .valid_in(valid_in), .a_in(a_in), .a_out(a_out1), .c_in(c_in),
        .c_out(c_out1), .valid_out(vo1), .ovf_clr(ovf_clr), .ovf(ovf1)
    );

    ws_pe_dbuf #(.DATA_WIDTH(8), .ACC_WIDTH(32), .PIPE(2), .SAT(0)) u_p2 (
        .clk(clk), .rst(rst), .enable(enable), .signed_mode(signed_mode),
        .b_load(b_load), .b_in(b_in), .b_out(b_out2), .b_swap(b_swap),
        .valid_in(valid_in), .a_in(a_in), .a_out(a_out2), .c_in(c_in),
        .c_out(c_out2), .valid_out(vo2), .ovf_clr(ovf_clr), .ovf(ovf2)
    );

    typedef struct {
        logic        ld;
        logic [7:0]  bi;
        logic        sw;
        logic        v;
        logic        sm;
        logic [7:0]  a;
        logic [31:0] c;
        logic        clr;
        logic [31:0] e1c;
        logic        e1v;
        logic        e1o;
        logic [31:0] e2c;
        logic        e2v;
        logic        e2o;
        logic [7:0]  eb;
    } vec_t;

    vec_t tbl [28];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx,
                           input logic [31:0] e1c, input logic e1v, input logic e1o,
                           input logic [31:0] e2c, input logic e2v, input logic e2o,
                           input logic [7:0] ea, input logic [7:0] eb);
        n_vec++;
        chk({tag, ".c_out1"}, idx, c_out1, e1c);
        chk({tag, ".valid_out1"}, idx, 32'(vo1), 32'(e1v));
        chk({tag, ".ovf1"}, idx, 32'(ovf1), 32'(e1o));
        chk({tag, ".c_out2"}, idx, c_out2, e2c);
        chk({tag, ".valid_out2"}, idx, 32'(vo2), 32'(e2v));
        chk({tag, ".ovf2"}, idx, 32'(ovf2), 32'(e2o));
        chk({tag, ".a_out1"}, idx, 32'(a_out1), 32'(ea));
        chk({tag, ".a_out2"}, idx, 32'(a_out2), 32'(ea));
        chk({tag, ".b_out1"}, idx, 32'(b_out1), 32'(eb));
        chk({tag, ".b_out2"}, idx, 32'(b_out2), 32'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [31:0] c);
        valid_in = v;
        a_in     = a;
        c_in     = c;
    endtask

    initial begin
        //            ld    bi     sw    v     sm    a      c              clr   e1c            e1v   e1o   e2c            e2v   e2o   eb
        tbl[0]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 8'h05};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 8'h05};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 32'd10,        1'b0, 32'd20,        1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 8'h05};
        tbl[3]  = '{1'b1, 8'hFD, 1'b0, 1'b1, 1'b1, 8'h01, 32'd0,         1'b0, 32'd5,         1'b1, 1'b0, 32'd20,        1'b1, 1'b0, 8'hFD};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 32'd0,         1'b0, 32'd10,        1'b1, 1'b0, 32'd5,         1'b1, 1'b0, 8'hFD};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 32'd0,         1'b0, 32'd15,        1'b1, 1'b0, 32'd10,        1'b1, 1'b0, 8'hFD};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd15,        1'b1, 1'b0, 8'hFD};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFC, 32'd15,        1'b0, 32'd27,        1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 8'hFD};
        tbl[8]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd27,        1'b1, 1'b0, 8'h07};
        tbl[9]  = '{1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 8'h09};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 32'd0,         1'b0, 32'd7,         1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 8'h09};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 32'd0,         1'b0, 32'd7,         1'b1, 1'b0, 32'd7,         1'b1, 1'b0, 8'h09};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 32'd0,         1'b0, 32'd9,         1'b1, 1'b0, 32'd7,         1'b1, 1'b0, 8'h09};
        tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h01, 32'd100,       1'b0, 32'd109,       1'b1, 1'b0, 32'd9,         1'b1, 1'b0, 8'hFF};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd109,       1'b1, 1'b0, 8'hFF};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 32'd0,         1'b0, 32'd65025,     1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 8'hFF};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 32'd0,         1'b0, 32'd1,         1'b1, 1'b0, 32'd65025,     1'b1, 1'b0, 8'hFF};
        tbl[17] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd1,         1'b1, 1'b0, 8'h05};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 8'h05};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 32'h7FFFFFF0,  1'b0, 32'h7FFFFFFF,  1'b1, 1'b1, 32'd0,         1'b0, 1'b0, 8'h05};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 32'd0,         1'b0, 32'd0,         1'b1, 1'b1, 32'h80000009,  1'b1, 1'b1, 8'h05};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 32'd0,         1'b1, 32'd0,         1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 8'h05};
        tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFB, 32'h80000000,  1'b0, 32'h80000000,  1'b1, 1'b1, 32'd0,         1'b1, 1'b0, 8'h05};
        tbl[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFB, 32'h80000000,  1'b1, 32'h80000000,  1'b1, 1'b1, 32'h7FFFFFE7,  1'b1, 1'b1, 8'h05};
        tbl[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0,         1'b1, 32'd0,         1'b0, 1'b0, 32'h7FFFFFE7,  1'b1, 1'b1, 8'h05};
        tbl[25] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 32'hFFFFFFF0,  1'b0, 32'hFFFFFFFF,  1'b1, 1'b1, 32'd0,         1'b0, 1'b1, 8'h05};
        tbl[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0,         1'b1, 32'd0,         1'b0, 1'b0, 32'h00000009,  1'b1, 1'b1, 8'h05};
        tbl[27] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0,         1'b1, 32'd0,         1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 8'h05};

        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < 28; i++) begin
            b_load      = tbl[i].ld;
            b_in        = tbl[i].bi;
            b_swap      = tbl[i].sw;
            signed_mode = tbl[i].sm;
            ovf_clr     = tbl[i].clr;
            drive(tbl[i].v, tbl[i].a, tbl[i].c);
            step();
            chk_all("vec", i, tbl[i].e1c, tbl[i].e1v, tbl[i].e1o,
                    tbl[i].e2c, tbl[i].e2v, tbl[i].e2o, tbl[i].a, tbl[i].eb);
        end

        // Stall: active weight is 5; stage1 of the PIPE=2 PE must keep the a=2 operand.
        b_load = 1'b0; b_swap = 1'b0; ovf_clr = 1'b0; signed_mode = 1'b1;
        drive(1'b1, 8'd1, 32'd0); step();
        chk_all("stall_pre", 0, 32'd5, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd1, 8'h05);
        drive(1'b1, 8'd2, 32'd0); step();
        chk_all("stall_pre", 1, 32'd10, 1'b1, 1'b0, 32'd5, 1'b1, 1'b0, 8'd2, 8'h05);
        enable = 1'b0;
        drive(1'b1, 8'd7, 32'd99);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", i, 32'd10, 1'b1, 1'b0, 32'd5, 1'b1, 1'b0, 8'd2, 8'h05);
        end
        enable = 1'b1;
        drive(1'b1, 8'd3, 32'd0); step();
        chk_all("stall_post", 0, 32'd15, 1'b1, 1'b0, 32'd10, 1'b1, 1'b0, 8'd3, 8'h05);
        drive(1'b1, 8'd4, 32'd0); step();
        chk_all("stall_post", 1, 32'd20, 1'b1, 1'b0, 32'd15, 1'b1, 1'b0, 8'd4, 8'h05);
        drive(1'b1, 8'd5, 32'h7FFFFFF0); step();
        chk_all("stall_post", 2, 32'h7FFFFFFF, 1'b1, 1'b1, 32'd20, 1'b1, 1'b0, 8'd5, 8'h05);

        // Asynchronous reset mid-cycle, then only post-release operands may appear.
        drive(1'b1, 8'd6, 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 8'd0, 32'd0); step();
        chk_all("post_rst", 0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 8'h00);
        drive(1'b1, 8'd3, 32'd4); step();
        chk_all("post_rst", 1, 32'd4, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd3, 8'h00);
        drive(1'b0, 8'd0, 32'd0); step();
        chk_all("post_rst", 2, 32'd0, 1'b0, 1'b0, 32'd4, 1'b1, 1'b0, 8'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
